// File: rtl/qsys_descriptor_mem_arbiter.sv
// Round-robin arbiter sharing one port of the SGDMA descriptor RAM among CPU (m0), read master (m1) and write-back master (m2).
// Define DESC_ARB_LOCK_EN to enable the m0 lock FSM with LOCK_MAX timeout; without it m0_lock is ignored.
module qsys_descriptor_mem_arbiter #(
    parameter int ADDR_W   = 7,
    parameter int DATA_W   = 32,
    parameter int LOCK_MAX = 64
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic [ADDR_W-1:0]     m0_address,
    input  logic [DATA_W/8-1:0]   m0_byteenable,
    input  logic                  m0_read,
    input  logic                  m0_write,
    input  logic [DATA_W-1:0]     m0_writedata,
    output logic                  m0_waitrequest,
    output logic [DATA_W-1:0]     m0_readdata,
    output logic                  m0_readdatavalid,
    input  logic                  m0_lock,

    input  logic [ADDR_W-1:0]     m1_address,
    input  logic [DATA_W/8-1:0]   m1_byteenable,
    input  logic                  m1_read,
    input  logic                  m1_write,
    input  logic [DATA_W-1:0]     m1_writedata,
    output logic                  m1_waitrequest,
    output logic [DATA_W-1:0]     m1_readdata,
    output logic                  m1_readdatavalid,

    input  logic [ADDR_W-1:0]     m2_address,
    input  logic [DATA_W/8-1:0]   m2_byteenable,
    input  logic                  m2_read,
    input  logic                  m2_write,
    input  logic [DATA_W-1:0]     m2_writedata,
    output logic                  m2_waitrequest,
    output logic [DATA_W-1:0]     m2_readdata,
    output logic                  m2_readdatavalid,

    output logic [ADDR_W-1:0]     ram_address,
    output logic [DATA_W/8-1:0]   ram_byteenable,
    output logic                  ram_chipselect,
    output logic                  ram_write,
    output logic [DATA_W-1:0]     ram_writedata,
    input  logic [DATA_W-1:0]     ram_readdata,

    output logic                  lock_timeout
);
    localparam int BE_W = DATA_W / 8;

    logic [2:0][ADDR_W-1:0] reqAddr;
    logic [2:0][BE_W-1:0]   reqBe;
    logic [2:0][DATA_W-1:0] reqData;
    logic [2:0]             reqWrite;
    logic [2:0]             active;
    logic [2:0]             eligible;
    logic                   locked;
    logic                   grantValid;
    logic [1:0]             grantId;

    logic [1:0] ptr_q, ptr_d;
    logic       rdValid_q;
    logic [1:0] rdId_q;

    assign reqAddr  = {m2_address, m1_address, m0_address};
    assign reqBe    = {m2_byteenable, m1_byteenable, m0_byteenable};
    assign reqData  = {m2_writedata, m1_writedata, m0_writedata};
    assign reqWrite = {m2_write, m1_write, m0_write};
    assign active   = {m2_read | m2_write, m1_read | m1_write, m0_read | m0_write};
    assign eligible = locked ? (active & 3'b001) : active;

    function automatic logic [1:0] rrIndex(input logic [1:0] base, input logic [1:0] offset);
        logic [2:0] sum;
        sum = {1'b0, base} + {1'b0, offset};
        return (sum >= 3'd3) ? 2'(sum - 3'd3) : sum[1:0];
    endfunction

    // Scan p, p+1, p+2 (mod 3); the first eligible requester wins this cycle.
    always_comb begin
        grantValid = 1'b0;
        grantId    = 2'd0;
        for (int k = 0; k < 3; k++) begin
            if (!grantValid && eligible[rrIndex(ptr_q, 2'(k))]) begin
                grantValid = 1'b1;
                grantId    = rrIndex(ptr_q, 2'(k));
            end
        end
    end

    always_comb begin
        ram_address    = reqAddr[0];
        ram_byteenable = reqBe[0];
        ram_writedata  = reqData[0];
        ram_chipselect = grantValid;
        ram_write      = 1'b0;
        if (grantValid) begin
            ram_address    = reqAddr[grantId];
            ram_byteenable = reqBe[grantId];
            ram_writedata  = reqData[grantId];
            ram_write      = reqWrite[grantId];
        end
    end

    assign m0_waitrequest = !(grantValid && grantId == 2'd0);
    assign m1_waitrequest = !(grantValid && grantId == 2'd1);
    assign m2_waitrequest = !(grantValid && grantId == 2'd2);

    // The pointer freezes while m0 holds a lock so the others resume in their old order.
    assign ptr_d = (grantValid && !locked) ? rrIndex(grantId, 2'd1) : ptr_q;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            ptr_q     <= 2'd0;
            rdValid_q <= 1'b0;
            rdId_q    <= 2'd0;
        end else begin
            ptr_q     <= ptr_d;
            rdValid_q <= grantValid & ~reqWrite[grantId];
            rdId_q    <= grantId;
        end
    end

    // Gating with reset_n drops a response whose grant preceded a reset.
    assign m0_readdatavalid = rdValid_q && reset_n && rdId_q == 2'd0;
    assign m1_readdatavalid = rdValid_q && reset_n && rdId_q == 2'd1;
    assign m2_readdatavalid = rdValid_q && reset_n && rdId_q == 2'd2;
    assign m0_readdata      = ram_readdata;
    assign m1_readdata      = ram_readdata;
    assign m2_readdata      = ram_readdata;

`ifdef DESC_ARB_LOCK_EN
    localparam int CNT_W = $clog2(LOCK_MAX) + 1;

    typedef enum logic [1:0] {IDLE, LOCKED, BACKOFF} lockState_t;

    lockState_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             timeout_q, timeout_d;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Dropping the lock takes precedence over a timeout landing in the same cycle.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        timeout_d = timeout_q;
        unique case (state_q)
            IDLE: begin
                if (grantValid && grantId == 2'd0 && m0_lock) begin
                    state_d = LOCKED;
                    cnt_d   = '0;
                end
            end
            LOCKED: begin
                cnt_d = cnt_q + 1'b1;
                if (!m0_lock) begin
                    state_d = IDLE;
                end else if (cnt_q == CNT_W'(LOCK_MAX - 1)) begin
                    state_d   = BACKOFF;
                    timeout_d = 1'b1;
                end
            end
            BACKOFF: begin
                if (!m0_lock) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign locked       = (state_q == LOCKED);
    assign lock_timeout = timeout_q;
`else
    logic unusedLock;
    assign unusedLock   = m0_lock;
    assign locked       = 1'b0;
    assign lock_timeout = 1'b0;
`endif

endmodule
